mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM pipeline stage: owns the data memory and performs loads and stores for the instruction in EX/MEM. Feeds the MEM/WB latch: read_data_out drives its read_data_in in the same cycle. Supports byte, halfword and word accesses with sign or zero extension, and flags misaligned accesses. After every reset it runs a hardware clear sequence, then exposes a registered debug read port for the debug unit.

Parameters:
DATA_WIDTH, 32, data path width (fixed at 32; byte lanes assume 4 bytes/word)
ADDR_BITS, 8, word-address bits; DEPTH = 2**ADDR_BITS words

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
alu_result_in  in  32  byte address from EX/MEM
write_data_in  in  32  store data (rt value) from EX/MEM
mem_read_in  in  1  load enable
mem_write_in  in  1  store enable
mem_size_in  in  2  access size: MEM_SIZE_BYTE=00, MEM_SIZE_HALF=01, MEM_SIZE_WORD=10; 11 treated as word
mem_unsigned_in  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
debug_addr_in  in  ADDR_BITS  word address for debug read
read_data_out  out  32  aligned, extended load result (combinational)
misaligned_out  out  1  current access violates alignment (combinational)
busy_out  out  1  clear sequence in progress; hazard unit stalls the pipeline
debug_data_out  out  32  registered word at debug_addr_in

Behaviour:
- Word index = alu_result_in[ADDR_BITS+1:2]; bits above are ignored (address wraps modulo DEPTH words). Byte lanes are little-endian: lane k = bits [8k+7:8k].
- FSM states: CLEAR, READY.
  - reset=1: state <= CLEAR, clr_idx <= 0, debug_data_out <= 0.
  - CLEAR: each cycle writes 0 to word clr_idx and increments clr_idx. On clr_idx = DEPTH-1 the state moves to READY at the next edge. busy_out = 1 in CLEAR, so it is high for exactly DEPTH cycles after reset deasserts.
  - READY: stays in READY until reset.
  - Reset asserted mid-clear restarts the clear from word 0.
- During CLEAR, pipeline stores are ignored and read_data_out = 0.
- misaligned_out = 1 when (mem_read_in | mem_write_in) and either:
  - half access with addr[0] = 1, or
  - word access with addr[1:0] != 0.
  - Byte accesses are never misaligned.
- Store (READY, mem_write_in=1, misaligned_out=0) commits at the posedge:
  - byte: write_data_in[7:0] to lane addr[1:0]
  - half: write_data_in[15:0] to lanes {addr[1],0} and {addr[1],1}
  - word: all 32 bits
  - Unselected lanes are unchanged. Misaligned stores are dropped entirely.
- Load (combinational from the array):
  - byte: lane addr[1:0]
  - half: halfword addr[1]
  - word: whole word
  - Sign- or zero-extended per mem_unsigned_in; word loads are unaffected by it.
  - read_data_out = 0 when mem_read_in=0, misaligned, or CLEAR.
- Same-cycle load and store to the same word (mem_read_in and mem_write_in both high) returns the pre-store contents; the new data is visible from the next cycle.
- Debug port: debug_data_out <= mem[debug_addr_in] every cycle (1-cycle latency), including during CLEAR. A pipeline store and a debug read of the same word in the same edge return the old value.
- Reset values: busy_out=1 (state CLEAR), debug_data_out=0, clr_idx=0. read_data_out and misaligned_out are combinational with no reset value; memory contents are defined only after the clear completes.

Decomposition:
- mips_pkg.vh gains MEM_SIZE_BYTE/HALF/WORD, MEM_STATE_CLEAR/READY, and reuses DATA_WIDTH.
- One combinational sub-module, mem_load_align: takes word, addr[1:0], size, unsigned and returns the extended data. It is shared with any future load-forwarding path.
- The storage array with byte-lane write enables stays inline in mem_stage.

Test Plan:
- Clear: ADDR_BITS=4, preload garbage via force, pulse reset 1 cycle -> busy_out high exactly 16 cycles; every debug read then returns 0x00000000.
- Word: after READY, SW 0xDEADBEEF @0x10; next cycle LW @0x10 -> read_data_out=0xDEADBEEF.
- Byte: SB 0x000000F0 @0x13 onto word 0x11223344 -> word 0xF0223344.
  - LB @0x13 -> 0xFFFFFFF0.
  - LBU @0x13 -> 0x000000F0.
- Half: LH @0x12 on word 0x8001AAAA -> 0xFFFF8001; LHU -> 0x00008001.
- Misaligned: SW 0x12345678 @0x21 -> misaligned_out=1, word 0x20 unchanged. LH @0x01 -> misaligned_out=1, read_data_out=0.
- Reset mid-clear:
  - Reset at clr_idx=7 -> clear restarts at 0; busy_out high 16 more cycles.
  - Store issued during busy is ignored.
  - Debug read of a word shows its value one cycle after debug_addr_in changes.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage: access sizes,
// clear-sequence FSM states and the fixed data path width.
package mem_stage_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic {
    MEM_STATE_CLEAR = 1'b0,
    MEM_STATE_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it to the full data width.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0]            sb;
    logic signed [DATA_WIDTH-1:0] sw;
    sb = b;
    sw = sb;
    return zext ? {{(DATA_WIDTH-8){1'b0}}, b} : sw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_half(input logic [15:0] h, input logic zext);
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] sw;
    sh = h;
    sw = sh;
    return zext ? {{(DATA_WIDTH-16){1'b0}}, h} : sw;
  endfunction

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    lane = 8'h00;
    case (offset)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
    half = offset[1] ? word[31:16] : word[15:0];
  end

  // Size 11 falls through to a full word, same as MEM_SIZE_WORD.
  always_comb begin
    data = word;
    case (size)
      MEM_SIZE_BYTE: data = extend_byte(lane, is_unsigned);
      MEM_SIZE_HALF: data = extend_half(half, is_unsigned);
      default:       data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory with byte-lane stores, aligned/extended
// loads, misalignment detection, a post-reset clear sequence and a debug port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  input  logic [ADDR_BITS-1:0]  debug_addr_in,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  misaligned_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] debug_data_out
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  mem_state_t            state;
  mem_state_t            state_nxt;
  logic [ADDR_BITS-1:0]  clr_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]  word_idx;
  logic [1:0]            offset;
  logic                  ready;
  logic                  store_en;
  logic [3:0]            lane_we;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  unused_addr_bits;

  // Address bits above the word index wrap the access modulo DEPTH words.
  assign word_idx         = alu_result_in[ADDR_BITS+1:2];
  assign offset           = alu_result_in[1:0];
  assign unused_addr_bits = ^alu_result_in[DATA_WIDTH-1:ADDR_BITS+2];

  always_ff @(posedge clk) begin
    if (reset) state <= MEM_STATE_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == MEM_STATE_CLEAR && (&clr_idx)) state_nxt = MEM_STATE_READY;
  end

  always_comb begin
    busy_out = (state == MEM_STATE_CLEAR);
    ready    = (state == MEM_STATE_READY);
  end

  always_ff @(posedge clk) begin
    if (reset)         clr_idx <= '0;
    else if (busy_out) clr_idx <= clr_idx + 1'b1;
  end

  always_comb begin
    misaligned_out = 1'b0;
    if (mem_read_in || mem_write_in) begin
      case (mem_size_in)
        MEM_SIZE_BYTE: misaligned_out = 1'b0;
        MEM_SIZE_HALF: misaligned_out = offset[0];
        default:       misaligned_out = |offset;
      endcase
    end
  end

  // Store data is replicated across lanes so each enabled lane picks its slice.
  always_comb begin
    lane_we   = 4'b1111;
    lane_data = write_data_in;
    case (mem_size_in)
      MEM_SIZE_BYTE: begin
        lane_we   = 4'b0001 << offset;
        lane_data = {4{write_data_in[7:0]}};
      end
      MEM_SIZE_HALF: begin
        lane_we   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data_in[15:0]}};
      end
      default: begin
        lane_we   = 4'b1111;
        lane_data = write_data_in;
      end
    endcase
  end

  assign store_en = ready && mem_write_in && !misaligned_out;

  always_ff @(posedge clk) begin
    if (busy_out) begin
      mem[clr_idx] <= '0;
    end else if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  // Debug read samples the array before any same-edge store lands.
  always_ff @(posedge clk) begin
    if (reset) debug_data_out <= '0;
    else       debug_data_out <= mem[debug_addr_in];
  end

  mem_load_align u_load_align (
    .word        (mem[word_idx]),
    .offset      (offset),
    .size        (mem_size_in),
    .is_unsigned (mem_unsigned_in),
    .data        (aligned)
  );

  assign read_data_out = (ready && mem_read_in && !misaligned_out) ? aligned : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (ADDR_BITS=4): clear sequence, word/byte/half
// loads and stores, misalignment, debug port and reset during clear.
module tb_mem_stage;

  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   alu_result_in;
  logic [31:0]   write_data_in;
  logic          mem_read_in;
  logic          mem_write_in;
  logic [1:0]    mem_size_in;
  logic          mem_unsigned_in;
  logic [AB-1:0] debug_addr_in;
  logic [31:0]   read_data_out;
  logic          misaligned_out;
  logic          busy_out;
  logic [31:0]   debug_data_out;

  int checks = 0;
  int fails  = 0;

  mem_stage #(.ADDR_BITS(AB)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_result_in   (alu_result_in),
    .write_data_in   (write_data_in),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_size_in     (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .debug_addr_in   (debug_addr_in),
    .read_data_out   (read_data_out),
    .misaligned_out  (misaligned_out),
    .busy_out        (busy_out),
    .debug_data_out  (debug_data_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read_in     = 1'b0;
    mem_write_in    = 1'b0;
    mem_unsigned_in = 1'b0;
    mem_size_in     = 2'b10;
    alu_result_in   = 32'h0;
    write_data_in   = 32'h0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    alu_result_in = addr;
    write_data_in = data;
    mem_size_in   = size;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b1;
    step();
    idle();
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    alu_result_in   = addr;
    mem_size_in     = size;
    mem_unsigned_in = uns;
    mem_read_in     = 1'b1;
    mem_write_in    = 1'b0;
    #1;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int c = 0; c < 64 && busy_out; c++) begin
      cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    debug_addr_in = '0;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (busy_out !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy_out); end
    checks++;
    if (debug_data_out !== 32'h0) begin fails++; $display("FAIL reset_debug: got %h expected 00000000", debug_data_out); end
    reset = 1'b0;
    count_busy(cnt);
    checks++;
    if (cnt !== 16) begin fails++; $display("FAIL first_clear_len: got %0d expected 16", cnt); end
    checks++;
    if (busy_out !== 1'b0) begin fails++; $display("FAIL ready_busy: got %b expected 0", busy_out); end
  endtask

  task automatic test_clear_garbage();
    int cnt;
    for (int i = 0; i < 16; i++) store(i * 4, 32'hA5A50000 | i, 2'b10);
    debug_addr_in = 4'd3;
    step();
    checks++;
    if (debug_data_out !== 32'hA5A50003) begin fails++; $display("FAIL garbage_preload: got %h expected a5a50003", debug_data_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(cnt);
    checks++;
    if (cnt !== 16) begin fails++; $display("FAIL clear_len: got %0d expected 16", cnt); end
    for (int i = 0; i < 16; i++) begin
      debug_addr_in = AB'(i);
      step();
      checks++;
      if (debug_data_out !== 32'h0) begin fails++; $display("FAIL cleared_word_%0d: got %h expected 00000000", i, debug_data_out); end
    end
  endtask

  task automatic test_word();
    store(32'h10, 32'hDEADBEEF, 2'b10);
    load(32'h10, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL lw: got %h expected deadbeef", read_data_out); end
    load(32'h50, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_wrap: got %h expected deadbeef", read_data_out); end
    mem_write_in  = 1'b1;
    write_data_in = 32'h01020304;
    alu_result_in = 32'h10;
    #1;
    checks++;
    if (read_data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_sw_same_cycle: got %h expected deadbeef", read_data_out); end
    step();
    mem_write_in = 1'b0;
    #1;
    checks++;
    if (read_data_out !== 32'h01020304) begin fails++; $display("FAIL lw_after_sw: got %h expected 01020304", read_data_out); end
    load(32'h11, 2'b11, 1'b0);
    checks++;
    if (misaligned_out !== 1'b1) begin fails++; $display("FAIL size11_misaligned: got %b expected 1", misaligned_out); end
    idle();
  endtask

  task automatic test_byte();
    store(32'h10, 32'h11223344, 2'b10);
    store(32'h13, 32'h000000F0, 2'b00);
    load(32'h10, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'hF0223344) begin fails++; $display("FAIL sb_word: got %h expected f0223344", read_data_out); end
    load(32'h13, 2'b00, 1'b0);
    checks++;
    if (read_data_out !== 32'hFFFFFFF0) begin fails++; $display("FAIL lb: got %h expected fffffff0", read_data_out); end
    load(32'h13, 2'b00, 1'b1);
    checks++;
    if (read_data_out !== 32'h000000F0) begin fails++; $display("FAIL lbu: got %h expected 000000f0", read_data_out); end
    load(32'h11, 2'b00, 1'b0);
    checks++;
    if (read_data_out !== 32'h00000033 || misaligned_out !== 1'b0) begin
      fails++; $display("FAIL lb_lane1: got %h/%b expected 00000033/0", read_data_out, misaligned_out);
    end
    idle();
  endtask

  task automatic test_half();
    store(32'h10, 32'h8001AAAA, 2'b10);
    load(32'h12, 2'b01, 1'b0);
    checks++;
    if (read_data_out !== 32'hFFFF8001) begin fails++; $display("FAIL lh: got %h expected ffff8001", read_data_out); end
    load(32'h12, 2'b01, 1'b1);
    checks++;
    if (read_data_out !== 32'h00008001) begin fails++; $display("FAIL lhu: got %h expected 00008001", read_data_out); end
    load(32'h10, 2'b01, 1'b0);
    checks++;
    if (read_data_out !== 32'hFFFFAAAA) begin fails++; $display("FAIL lh_low: got %h expected ffffaaaa", read_data_out); end
    idle();
    store(32'h10, 32'hABCD7FFF, 2'b01);
    load(32'h10, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'h80017FFF) begin fails++; $display("FAIL sh_word: got %h expected 80017fff", read_data_out); end
    idle();
  endtask

  task automatic test_misaligned();
    store(32'h20, 32'h0BADCAFE, 2'b10);
    alu_result_in = 32'h21;
    write_data_in = 32'h12345678;
    mem_size_in   = 2'b10;
    mem_write_in  = 1'b1;
    #1;
    checks++;
    if (misaligned_out !== 1'b1) begin fails++; $display("FAIL sw_misaligned_flag: got %b expected 1", misaligned_out); end
    step();
    idle();
    load(32'h20, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'h0BADCAFE) begin fails++; $display("FAIL sw_misaligned_dropped: got %h expected 0badcafe", read_data_out); end
    load(32'h01, 2'b01, 1'b0);
    checks++;
    if (misaligned_out !== 1'b1 || read_data_out !== 32'h0) begin
      fails++; $display("FAIL lh_misaligned: got %b/%h expected 1/00000000", misaligned_out, read_data_out);
    end
    idle();
    alu_result_in = 32'h21;
    #1;
    checks++;
    if (misaligned_out !== 1'b0) begin fails++; $display("FAIL no_access_flag: got %b expected 0", misaligned_out); end
    idle();
  endtask

  task automatic test_debug();
    store(32'h18, 32'h66666666, 2'b10);
    store(32'h1C, 32'h77777777, 2'b10);
    debug_addr_in = 4'd6;
    step();
    checks++;
    if (debug_data_out !== 32'h66666666) begin fails++; $display("FAIL debug_w6: got %h expected 66666666", debug_data_out); end
    debug_addr_in = 4'd7;
    #1;
    checks++;
    if (debug_data_out !== 32'h66666666) begin fails++; $display("FAIL debug_latency: got %h expected 66666666", debug_data_out); end
    step();
    checks++;
    if (debug_data_out !== 32'h77777777) begin fails++; $display("FAIL debug_w7: got %h expected 77777777", debug_data_out); end
    store(32'h1C, 32'h70707070, 2'b10);
    checks++;
    if (debug_data_out !== 32'h77777777) begin fails++; $display("FAIL debug_same_edge: got %h expected 77777777", debug_data_out); end
    step();
    checks++;
    if (debug_data_out !== 32'h70707070) begin fails++; $display("FAIL debug_after_store: got %h expected 70707070", debug_data_out); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    store(32'h3C, 32'hCAFEF00D, 2'b10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    load(32'h3C, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'h0) begin fails++; $display("FAIL load_during_clear: got %h expected 00000000", read_data_out); end
    idle();
    debug_addr_in = 4'd15;
    step();
    checks++;
    if (debug_data_out !== 32'hCAFEF00D) begin fails++; $display("FAIL debug_during_clear: got %h expected cafef00d", debug_data_out); end
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 64 && busy_out; c++) begin
      cnt++;
      if (cnt == 16) begin
        alu_result_in = 32'h04;
        write_data_in = 32'h12345678;
        mem_size_in   = 2'b10;
        mem_write_in  = 1'b1;
      end
      step();
    end
    idle();
    checks++;
    if (cnt !== 16) begin fails++; $display("FAIL restart_clear_len: got %0d expected 16", cnt); end
    load(32'h04, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'h0) begin fails++; $display("FAIL store_during_busy: got %h expected 00000000", read_data_out); end
    load(32'h3C, 2'b10, 1'b0);
    checks++;
    if (read_data_out !== 32'h0) begin fails++; $display("FAIL word15_cleared: got %h expected 00000000", read_data_out); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear_garbage();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_debug();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
